gate_vector_sequencer: RTL and testbench

- Self-checking stimulus stage placed directly upstream of a 2-input gate under test.
- Walks all four {a,b} input combinations, holds each for a settle window, then samples the gate's two outputs (x, y).
- Compares each sample against parameterised truth tables and reports a mismatch count plus pass/done status.
- Replaces hand-written #delay stimulus with a clocked, synthesizable sequencer reusable across gate labs.

---
 rtl/gate_vector_sequencer.sv | 152 +++++++++++++++
 tb/tb_gate_vector_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: clocked stimulus/check stage for a 2-input gate.
// Walks {a,b} = 00,01,10,11, holds each vector HOLD_CYCLES cycles, samples
// the gate outputs (x_in, y_in) for one cycle and counts truth-table mismatches.
// Optional first-failure capture is enabled by defining GATE_SEQ_FIRSTFAIL_EN.
module gate_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXPECT_X    = 4'b1000,
    parameter logic [3:0]  EXPECT_Y    = 4'b0111,
    parameter int unsigned ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             x_in,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef GATE_SEQ_FIRSTFAIL_EN
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [1:0]       fail_xy,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [1:0]       vec, vec_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [ERR_W-1:0] err_next;
    logic             a_next, b_next, busy_next, done_next, pass_next;
    logic             mismatch_c;
`ifdef GATE_SEQ_FIRSTFAIL_EN
    logic             fail_valid_next;
    logic [1:0]       fail_vec_next;
    logic [1:0]       fail_xy_next;
`endif

    // Compare the sampled gate outputs against the expected truth tables.
    assign mismatch_c = (x_in != EXPECT_X[vec]) || (y_in != EXPECT_Y[vec]);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state;
        vec_next   = vec;
        cnt_next   = cnt;
        err_next   = err_cnt;
`ifdef GATE_SEQ_FIRSTFAIL_EN
        fail_valid_next = fail_valid;
        fail_vec_next   = fail_vec;
        fail_xy_next    = fail_xy;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                    vec_next   = 2'd0;
                    cnt_next   = '0;
                    err_next   = '0;
`ifdef GATE_SEQ_FIRSTFAIL_EN
                    fail_valid_next = 1'b0;
                    fail_vec_next   = 2'd0;
                    fail_xy_next    = 2'd0;
`endif
                end
            end
            ST_DRIVE: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_c) begin
                    if (err_cnt != ERR_MAX) begin
                        err_next = err_cnt + ERR_W'(1);
                    end
`ifdef GATE_SEQ_FIRSTFAIL_EN
                    if (!fail_valid) begin
                        fail_valid_next = 1'b1;
                        fail_vec_next   = vec;
                        fail_xy_next    = {x_in, y_in};
                    end
`endif
                end
                if (vec == 2'd3) begin
                    state_next = ST_DONE;
                end else begin
                    vec_next   = vec + 2'd1;
                    cnt_next   = '0;
                    state_next = ST_DRIVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_DRIVE) || (state_next == ST_SAMPLE);
        a_next    = busy_next & vec_next[1];
        b_next    = busy_next & vec_next[0];
        done_next = (state_next == ST_DONE);
        pass_next = done_next && (err_next == '0);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vec     <= 2'd0;
            cnt     <= '0;
            err_cnt <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
`ifdef GATE_SEQ_FIRSTFAIL_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            fail_xy    <= 2'd0;
`endif
        end else begin
            state   <= state_next;
            vec     <= vec_next;
            cnt     <= cnt_next;
            err_cnt <= err_next;
            a       <= a_next;
            b       <= b_next;
            busy    <= busy_next;
            done    <= done_next;
            pass    <= pass_next;
`ifdef GATE_SEQ_FIRSTFAIL_EN
            fail_valid <= fail_valid_next;
            fail_vec   <= fail_vec_next;
            fail_xy    <= fail_xy_next;
`endif
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: a default instance driving an
// AND/NAND gate model with injectable faults, and an ERR_W=1 instance
// driving a gate with x stuck at 1. Honours GATE_SEQ_FIRSTFAIL_EN.
module tb_gate_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    logic y_stuck0;

    logic       a0, b0, busy0, done0, pass0, x0, y0;
    logic [2:0] err0;
    logic       a1, b1, busy1, done1, pass1, x1, y1;
    logic [0:0] err1;
`ifdef GATE_SEQ_FIRSTFAIL_EN
    logic       fv0, fv1;
    logic [1:0] fvec0, fvec1, fxy0, fxy1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate models: AND/NAND with optional y stuck-at-0; second gate has x stuck-at-1.
    assign x0 = a0 & b0;
    assign y0 = y_stuck0 ? 1'b0 : ~(a0 & b0);
    assign x1 = 1'b1;
    assign y1 = ~(a1 & b1);

    gate_vector_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x_in(x0), .y_in(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef GATE_SEQ_FIRSTFAIL_EN
        .fail_valid(fv0), .fail_vec(fvec0), .fail_xy(fxy0),
`endif
        .err_cnt(err0)
    );

    gate_vector_sequencer #(.ERR_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x1), .y_in(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef GATE_SEQ_FIRSTFAIL_EN
        .fail_valid(fv1), .fail_vec(fvec1), .fail_xy(fxy1),
`endif
        .err_cnt(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one sweep on the selected instance; extra_at injects a second start pulse.
    task automatic sweep(input bit sel, input int extra_at, output int edges);
        edges = -1;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (sel ? done1 : done0) begin
                edges = j;
                break;
            end
            if (!sel) begin
                chk("ab_step", 32'({a0, b0}), 32'(j / 5));
                chk("busy", 32'(busy0), 32'd1);
                if (j == 0) begin
                    chk("start_pass_drop", 32'(pass0), 32'd0);
                    chk("start_err_clr", 32'(err0), 32'd0);
                end
            end
            if (sel) start1 = (j == extra_at); else start0 = (j == extra_at);
            tick();
        end
        start0 = 1'b0;
        start1 = 1'b0;
        if (edges < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int edges;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        y_stuck0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_ab", 32'({a0, b0}), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_pass", 32'(pass0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);

        // Correct gate: full sweep
        sweep(1'b0, -1, edges);
        chk("ok_latency", 32'(edges), 32'd20);
        chk("ok_pass", 32'(pass0), 32'd1);
        chk("ok_err", 32'(err0), 32'd0);
        chk("ok_done_ab", 32'({a0, b0, busy0}), 32'd0);
        tick();
        chk("done_hold", 32'({done0, pass0}), 32'b11);

        // y stuck at 0: vectors 00,01,10 fail
        y_stuck0 = 1'b1;
        sweep(1'b0, -1, edges);
        chk("ys0_latency", 32'(edges), 32'd20);
        chk("ys0_err", 32'(err0), 32'd3);
        chk("ys0_pass", 32'(pass0), 32'd0);
`ifdef GATE_SEQ_FIRSTFAIL_EN
        chk("ys0_fail_valid", 32'(fv0), 32'd1);
        chk("ys0_fail_vec", 32'(fvec0), 32'd0);
        chk("ys0_fail_xy", 32'(fxy0), 32'd0);
`endif

        // From failed DONE, restart with correct gate; extra start at cycle 3 ignored
        y_stuck0 = 1'b0;
        sweep(1'b0, 3, edges);
        chk("restart_latency", 32'(edges), 32'd20);
        chk("restart_err", 32'(err0), 32'd0);
        chk("restart_pass", 32'(pass0), 32'd1);
`ifdef GATE_SEQ_FIRSTFAIL_EN
        chk("restart_fail_valid", 32'(fv0), 32'd0);
`endif

        // Reset mid-sweep during vector 10 with two errors already counted
        y_stuck0 = 1'b1;
        start0   = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (11) tick();
        chk("mid_ab", 32'({a0, b0}), 32'd2);
        chk("mid_err", 32'(err0), 32'd2);
        rst_n  = 1'b0;
        start0 = 1'b1;
        tick();
        rst_n  = 1'b1;
        start0 = 1'b0;
        chk("midrst_ab", 32'({a0, b0}), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_err", 32'(err0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        tick();
        chk("midrst_idle", 32'({busy0, done0}), 32'd0);
        y_stuck0 = 1'b0;
        sweep(1'b0, -1, edges);
        chk("post_rst_latency", 32'(edges), 32'd20);
        chk("post_rst_pass", 32'(pass0), 32'd1);

        // ERR_W=1 with x stuck at 1: three mismatches saturate at 1
        sweep(1'b1, -1, edges);
        chk("sat_latency", 32'(edges), 32'd20);
        chk("sat_err", 32'(err1), 32'd1);
        chk("sat_pass", 32'(pass1), 32'd0);
        chk("sat_done", 32'(done1), 32'd1);
`ifdef GATE_SEQ_FIRSTFAIL_EN
        chk("sat_fail_vec", 32'(fvec1), 32'd0);
        chk("sat_fail_xy", 32'(fxy1), 32'b11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
